// File: rtl/size_explore_pkg.sv
// Shared definitions for the size-exploration datapath front end.
// Holds the FSM state encoding and the operand width limits.
package size_explore_pkg;

    localparam int DEFAULT_WIDTH = 6;
    localparam int MAX_WIDTH     = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/operand_shift_reg.sv
// Serial-in/parallel-out operand shifter. It stores only the upper WIDTH-1 bits;
// next_value appends the bit on the wire, giving the full operand on the cycle that carries bit 0.
module operand_shift_reg
    import size_explore_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             load_first,
    input  logic             bit_in,
    output logic [WIDTH-1:0] next_value
);

    logic [WIDTH-2:0] sr_reg;
    logic [WIDTH-2:0] shift_next;
    logic [WIDTH-2:0] first_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign shift_next[gi] = bit_in;
                assign first_next[gi] = bit_in;
            end else begin : g_upper
                assign shift_next[gi] = sr_reg[gi-1];
                assign first_next[gi] = 1'b0;
            end
        end
    endgenerate

    // A new frame clears any leftover bits so an aborted frame cannot leak through.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_reg <= '0;
        end else if (load_first) begin
            sr_reg <= first_next;
        end else if (shift_en) begin
            sr_reg <= shift_next;
        end
    end

    assign next_value = {sr_reg, bit_in};

endmodule

// File: rtl/serial_operand_loader.sv
// Framed deserializer for two MSB-first operand streams, presenting each completed
// pair over valid/ready while the next frame shifts in behind it.
module serial_operand_loader
    import size_explore_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             bit_a,
    input  logic             bit_b,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;
    logic             op_valid_reg;
    logic             busy_reg;
    logic             overrun_reg;

    logic             take_start;
    logic             shift_en;
    logic             frame_done;
    logic             accept_new;
    logic             drop_frame;
    logic [WIDTH-1:0] frame_a;
    logic [WIDTH-1:0] frame_b;

    assign take_start = enable & start;
    assign shift_en   = enable && (state_reg == ST_SHIFT) && !start;
    assign frame_done = enable && (state_reg == ST_SHIFT) && (cnt_reg == LAST_CNT);
    assign accept_new = frame_done && (!op_valid_reg || op_ready);
    assign drop_frame = frame_done && op_valid_reg && !op_ready;

    operand_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (shift_en),
        .load_first (take_start),
        .bit_in     (bit_a),
        .next_value (frame_a)
    );

    operand_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (shift_en),
        .load_first (take_start),
        .bit_in     (bit_b),
        .next_value (frame_b)
    );

    // Start wins over completion: on the last bit it both finishes this frame and opens the next.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (take_start) begin
            state_next = ST_SHIFT;
            cnt_next   = ONE_CNT;
        end else if (frame_done) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else if (shift_en) begin
            cnt_next   = cnt_reg + ONE_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= (state_next == ST_SHIFT);

            if (accept_new) begin
                op_a_reg     <= frame_a;
                op_b_reg     <= frame_b;
                op_valid_reg <= 1'b1;
            end else if (op_valid_reg && op_ready) begin
                op_valid_reg <= 1'b0;
            end

            if (drop_frame) begin
                overrun_reg <= 1'b1;
            end else if (clr_ovr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign op_a     = op_a_reg;
    assign op_b     = op_b_reg;
    assign op_valid = op_valid_reg;
    assign busy     = busy_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_serial_operand_loader.sv
// Bench for serial_operand_loader: directed frames with literal expectations, then random
// traffic, all checked every cycle against a bit-accumulating reference model.
module tb_serial_operand_loader;

    localparam int W    = 6;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         start = 1'b0;
    logic         bit_a = 1'b0;
    logic         bit_b = 1'b0;
    logic         clr_ovr = 1'b0;
    logic         op_ready = 1'b0;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_valid;
    logic         busy;
    logic         overrun;

    int vectors = 0;
    int miscompares = 0;

    serial_operand_loader #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .start    (start),
        .bit_a    (bit_a),
        .bit_b    (bit_b),
        .clr_ovr  (clr_ovr),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: bits received so far in the open frame, their value, and the output buffer.
    bit model_live = 1'b0;
    int m_nbits, m_acc_a, m_acc_b;
    int m_op_a, m_op_b;
    bit m_valid, m_ovr;
    int fa, fb;
    bit done, set_ovr;

    always @(posedge clk) begin
        if (reset) begin
            model_live = 1'b1;
            m_nbits = 0; m_acc_a = 0; m_acc_b = 0;
            m_op_a = 0; m_op_b = 0; m_valid = 1'b0; m_ovr = 1'b0;
        end else if (model_live) begin
            done = 1'b0;
            fa = 0; fb = 0;
            if (enable) begin
                if (m_nbits == W - 1) begin
                    done = 1'b1;
                    fa = (m_acc_a * 2 + int'(bit_a)) & MASK;
                    fb = (m_acc_b * 2 + int'(bit_b)) & MASK;
                    if (start) begin
                        m_nbits = 1; m_acc_a = int'(bit_a); m_acc_b = int'(bit_b);
                    end else begin
                        m_nbits = 0; m_acc_a = 0; m_acc_b = 0;
                    end
                end else if (start) begin
                    m_nbits = 1; m_acc_a = int'(bit_a); m_acc_b = int'(bit_b);
                end else if (m_nbits > 0) begin
                    m_acc_a = m_acc_a * 2 + int'(bit_a);
                    m_acc_b = m_acc_b * 2 + int'(bit_b);
                    m_nbits++;
                end
            end
            set_ovr = done && m_valid && !op_ready;
            if (m_valid && op_ready)
                $display("accept op_a=%02h op_b=%02h at %0t", m_op_a, m_op_b, $time);
            if (done && (!m_valid || op_ready)) begin
                m_op_a = fa; m_op_b = fb; m_valid = 1'b1;
            end else if (m_valid && op_ready) begin
                m_valid = 1'b0;
            end
            if (set_ovr) m_ovr = 1'b1;
            else if (clr_ovr) m_ovr = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            chk("op_a", 32'(op_a), 32'(m_op_a));
            chk("op_b", 32'(op_b), 32'(m_op_b));
            chk("op_valid", 32'(op_valid), 32'(m_valid));
            chk("busy", 32'(busy), (m_nbits > 0) ? 32'd1 : 32'd0);
            chk("overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    task automatic step(input bit en, input bit st, input bit ba, input bit bb,
                        input bit rdy, input bit clr);
        @(negedge clk);
        enable = en; start = st; bit_a = ba; bit_b = bb; op_ready = rdy; clr_ovr = clr;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit rdy);
        for (int i = W - 1; i >= 0; i--)
            step(1'b1, i == W - 1, a[i], b[i], rdy, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset op_valid", 32'(op_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset overrun", 32'(overrun), 32'd0);
        chk("reset op_a", 32'(op_a), 32'd0);
        reset = 1'b0;

        // Basic frame
        send(6'h2D, 6'h13, 1'b1);
        after_edge();
        chk("basic op_valid", 32'(op_valid), 32'd1);
        chk("basic op_a", 32'(op_a), 32'h2D);
        chk("basic op_b", 32'(op_b), 32'h13);
        chk("basic overrun", 32'(overrun), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        after_edge();
        chk("basic valid drop", 32'(op_valid), 32'd0);

        // Back-to-back frames
        send(6'h2D, 6'h13, 1'b1);
        after_edge();
        chk("b2b1 op_a", 32'(op_a), 32'h2D);
        send(6'h3F, 6'h00, 1'b1);
        after_edge();
        chk("b2b2 op_a", 32'(op_a), 32'h3F);
        chk("b2b2 op_b", 32'(op_b), 32'h00);
        send(6'h01, 6'h20, 1'b1);
        after_edge();
        chk("b2b3 op_a", 32'(op_a), 32'h01);
        chk("b2b3 op_b", 32'(op_b), 32'h20);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Stall for 3 cycles after bit 3; start and bits are ignored while disabled
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        after_edge();
        chk("stall op_valid", 32'(op_valid), 32'd1);
        chk("stall op_a", 32'(op_a), 32'h2D);
        chk("stall op_b", 32'(op_b), 32'h13);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun with consumer stalled
        send(6'h2D, 6'h13, 1'b0);
        after_edge();
        chk("ovr first valid", 32'(op_valid), 32'd1);
        send(6'h3F, 6'h00, 1'b0);
        after_edge();
        chk("ovr op_a held", 32'(op_a), 32'h2D);
        chk("ovr set", 32'(overrun), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        after_edge();
        chk("ovr cleared", 32'(overrun), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        after_edge();
        chk("ovr valid drop", 32'(op_valid), 32'd0);

        // Restart at bit 2 of frame 2D/13
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send(6'h15, 6'h2A, 1'b1);
        after_edge();
        chk("restart op_a", 32'(op_a), 32'h15);
        chk("restart op_b", 32'(op_b), 32'h2A);
        chk("restart overrun", 32'(overrun), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-frame with op_valid high
        send(6'h2D, 6'h13, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op_ready = 1'b1;
        after_edge();
        chk("rst op_valid", 32'(op_valid), 32'd0);
        chk("rst op_a", 32'(op_a), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        send(6'h3F, 6'h00, 1'b1);
        after_edge();
        chk("post-rst op_a", 32'(op_a), 32'h3F);
        chk("post-rst op_b", 32'(op_b), 32'h00);

        // Random traffic
        repeat (1500) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 99) == 0);
            enable   = ($urandom_range(0, 9) < 8);
            start    = ($urandom_range(0, 7) == 0);
            bit_a    = 1'($urandom);
            bit_b    = 1'($urandom);
            op_ready = ($urandom_range(0, 9) < 6);
            clr_ovr  = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        reset = 1'b0; enable = 1'b0; start = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
